// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the execute stage.
//   - icode constants (HALT..POPL) and the "no register" id RNONE
//   - condition ifun codes used by jXX and cmovXX
//   - ALU op codes (ifun of OPl)
//   - is_cond_icode(): true for the icodes whose behaviour depends on the CC
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVL = 4'h2;  // also cmovXX
  localparam logic [3:0] IRMOVL = 4'h3;
  localparam logic [3:0] RMMOVL = 4'h4;
  localparam logic [3:0] MRMOVL = 4'h5;
  localparam logic [3:0] OPL    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHL  = 4'hA;
  localparam logic [3:0] POPL   = 4'hB;

  localparam logic [3:0] RNONE  = 4'hF;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  function automatic logic is_cond_icode(input logic [3:0] icode);
    return (icode == RRMOVL) || (icode == JXX);
  endfunction

endpackage

// File: rtl/execute_cc_cond_eval.sv
// Combinational condition evaluator (module cond_eval).
// Ports:
//   ifun, icode   in  instruction fields of the execute-stage slot
//   sf, zf, of    in  registered condition codes
//   cnd           out condition result; 1 for icodes that are not cmov/jXX
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [3:0] icode,
  input  logic       sf,
  input  logic       zf,
  input  logic       of,
  output logic       cnd
);

  logic lt;
  logic raw;

  assign lt = sf ^ of;

  always_comb begin
    raw = 1'b0;
    case (ifun)
      C_ALWAYS: raw = 1'b1;
      C_LE:     raw = lt | zf;
      C_L:      raw = lt;
      C_E:      raw = zf;
      C_NE:     raw = ~zf;
      C_GE:     raw = ~lt;
      C_G:      raw = ~lt & ~zf;
      default:  raw = 1'b0;
    endcase
  end

  assign cnd = is_cond_icode(icode) ? raw : 1'b1;

endmodule

// File: rtl/execute_cc.sv
// Y86 execute-stage condition-code register and E->M pipeline register.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   e_valid, e_icode, e_ifun         execute-stage instruction
//   e_valA, e_dstE                   pass-through operand, destination reg
//   alu_out, alu_sf/zf/of            ALU result and its flags
//   m_exc, w_exc                     downstream exception pending
//   stall_m, bubble_m                M register control (stall wins)
//   e_cnd                            combinational condition from the CC
//   cc_sf, cc_zf, cc_of              architectural condition codes
//   M_valid..M_dstE                  registered E->M pipeline fields
module execute_cc
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic [31:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [31:0] alu_out,
  input  logic        alu_sf,
  input  logic        alu_zf,
  input  logic        alu_of,
  input  logic        m_exc,
  input  logic        w_exc,
  input  logic        stall_m,
  input  logic        bubble_m,
  output logic        e_cnd,
  output logic        cc_sf,
  output logic        cc_zf,
  output logic        cc_of,
  output logic        M_valid,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [31:0] M_valE,
  output logic [31:0] M_valA,
  output logic [3:0]  M_dstE
);

  logic set_cc;

  // Condition is taken from the registered CC, so an OPl's flags become
  // visible to the following instruction one cycle later.
  cond_eval u_cond (
    .ifun  (e_ifun),
    .icode (e_icode),
    .sf    (cc_sf),
    .zf    (cc_zf),
    .of    (cc_of),
    .cnd   (e_cnd)
  );

  // Flags are suppressed while an older instruction is excepting, and while
  // M is stalled (the OPl has not really left execute yet).
  assign set_cc = e_valid & (e_icode == OPL) & ~m_exc & ~w_exc & ~stall_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_sf <= 1'b0;
      cc_zf <= 1'b1;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_sf <= alu_sf;
      cc_zf <= alu_zf;
      cc_of <= alu_of;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (!stall_m && (bubble_m || !e_valid))) begin
      M_valid <= 1'b0;
      M_icode <= NOP;
      M_cnd   <= 1'b0;
      M_valE  <= 32'h0;
      M_valA  <= 32'h0;
      M_dstE  <= RNONE;
    end else if (!stall_m) begin
      M_valid <= 1'b1;
      M_icode <= e_icode;
      M_cnd   <= e_cnd;
      M_valE  <= alu_out;
      M_valA  <= e_valA;
      // An untaken cmov must not write its destination.
      M_dstE  <= ((e_icode == RRMOVL) && !e_cnd) ? RNONE : e_dstE;
    end
  end

endmodule

// File: doc/execute_cc.md
EXECUTE_CC -- requirements
Module: execute_cc

Interface
REQ-001 The ports SHALL be, clock and reset first: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-002 e_valid  in  1  execute-stage slot holds a real instruction; e_icode  in  4  Y86 icode; e_ifun  in  4  Y86 ifun.
REQ-003 e_valA  in  32  pass-through operand; e_dstE  in  4  destination register, 4'hF = none.
REQ-004 alu_out  in  32  ALU result; alu_sf, alu_zf, alu_of  in  1 each  ALU flags for alu_out.
REQ-005 m_exc, w_exc  in  1 each  downstream exception pending (halt/bad address/bad instr).
REQ-006 stall_m  in  1  hold the M register; bubble_m  in  1  load a bubble into the M register.
REQ-007 e_cnd  out  1  combinational condition result, for branch-mispredict logic.
REQ-008 cc_sf, cc_zf, cc_of  out  1 each  architectural condition-code register.
REQ-009 M_valid  out  1; M_icode  out  4; M_cnd  out  1; M_valE  out  32; M_valA  out  32; M_dstE  out  4  registered execute-to-memory pipeline register.

Function
REQ-010 e_cnd SHALL be evaluated from the current registered CC (never from alu_* flags) by e_ifun: 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; 7-15 0.
REQ-011 e_cnd SHALL equal the REQ-010 value when e_icode is 2 (rrmovl/cmovXX) or 7 (jXX), and 1 for all other icodes.
REQ-012 The CC register SHALL load {alu_sf, alu_zf, alu_of} on a rising edge iff e_valid & (e_icode==6) & !m_exc & !w_exc & !stall_m & !reset; otherwise it SHALL hold.
REQ-013 Unless held by stall_m, the M register SHALL load with latency 1: M_valid=e_valid, M_icode=e_icode, M_cnd=e_cnd, M_valE=alu_out, M_valA=e_valA.
REQ-014 M_dstE SHALL load 4'hF when e_icode==2 and e_cnd==0 (untaken cmov); otherwise it SHALL load e_dstE.
REQ-015 When stall_m=1 the M register SHALL hold all fields; stall_m SHALL take priority over bubble_m.
REQ-016 When bubble_m=1 and stall_m=0, or when e_valid=0, the M register SHALL load the bubble value: M_valid=0, M_icode=4'h1 (nop), M_cnd=0, M_valE=0, M_valA=0, M_dstE=4'hF.
REQ-017 An instruction following an OPl SHALL observe the flags written by that OPl, one cycle later, in e_cnd.
REQ-018 Arithmetic SHALL be unsigned 32-bit pass-through; the block SHALL NOT modify alu_out or e_valA.

Reset
REQ-019 reset SHALL override stall_m, bubble_m and all data inputs on the same rising edge.
REQ-020 On reset: cc_zf=1, cc_sf=0, cc_of=0; the M register SHALL take the bubble value of REQ-016.
REQ-021 Reset asserted mid-stall SHALL discard the held M contents; the first post-reset edge with e_valid=1 SHALL load normally.

Structure
REQ-022 The shared package y86_pkg SHALL hold the icode constants (HALT..POPL), RNONE=4'hF, the condition ifun codes (ALWAYS, LE, L, E, NE, GE, G) and the ALU op codes.
REQ-023 Condition evaluation (REQ-010/011) SHALL be a separate combinational sub-module cond_eval(ifun, icode, sf, zf, of -> cnd); the CC and M registers stay in execute_cc.

Verification
REQ-024 Reset, then idle -> cc={sf0,zf1,of0}, M_valid=0, M_icode=1, M_dstE=F; jXX ifun=3 presented -> e_cnd=1.
REQ-025 OPl, alu_out=0x80000000, sf=1, zf=0, of=1 -> next cycle cc={1,0,1}, M_valE=0x80000000; then jXX ifun=2 (jl) -> e_cnd=0; ifun=5 (jge) -> e_cnd=1.
REQ-026 cmovXX ifun=3, dstE=2 with cc_zf=0 -> M_dstE=F, M_cnd=0; repeat with cc_zf=1 -> M_dstE=2, M_cnd=1.
REQ-027 OPl with zf=1 while m_exc=1 -> CC unchanged; same OPl with m_exc=0 and w_exc=1 -> CC unchanged; with both 0 -> cc_zf=1.
REQ-028 M holding valE=0x1234, stall_m=1 and bubble_m=1 for 3 cycles with changing inputs -> M held at 0x1234 and CC unchanged; then bubble_m alone -> bubble value.
REQ-029 reset asserted during stall_m with OPl on inputs -> bubble value and cc={0,1,0} after that edge.
